ws2812_serializer: RTL and testbench

- Downstream stage of the WS2812 register block. Consumes the pixel RAM the register block fills, plus its number_of_pixels value.
- Continuously refreshes the LED strip. Each frame reads number_of_pixels*3 bytes over the RAM's second (read-only) port and serialises them MSB-first onto the single-wire WS2812 data line using NRZ pulse-width timing.
- Each frame is followed by a low latch gap.

---
 rtl/ws2812_pkg.sv | 40 ++++
 rtl/ws2812_serializer.sv | 192 +++++++++++++++++++
 tb/tb_ws2812_serializer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared types and default timing for the WS2812 serializer.
//               Holds the frame-sequencer state encoding, default timing
//               values (27 MHz clock) and a helper that converts a pixel
//               count into a byte count.
// Revision    : 1.0  initial release
// ============================================================================
package ws2812_pkg;

    // Default timing at 27 MHz: 1.25 us bit period, 80 us latch gap
    localparam int DEF_BIT_CYCLES   = 34;
    localparam int DEF_T0H_CYCLES   = 11;
    localparam int DEF_T1H_CYCLES   = 22;
    localparam int DEF_LATCH_CYCLES = 2160;

    // Datapath widths
    localparam int PIXEL_ADDR_W = 10;
    localparam int PHASE_W      = 6;
    localparam int LATCH_W      = 12;

    // Frame sequencer states
    typedef enum logic [2:0] {
        LATCH    = 3'd0,
        FETCH    = 3'd1,
        LOAD     = 3'd2,
        BIT_HIGH = 3'd3,
        BIT_LOW  = 3'd4
    } ws_state_t;

    // Three bytes (G, R, B) per pixel; 255 pixels -> 765, fits 10 bits
    function automatic logic [PIXEL_ADDR_W-1:0] frame_bytes(input logic [7:0] npix);
        logic [PIXEL_ADDR_W-1:0] n;
        n = PIXEL_ADDR_W'(npix);
        return (n << 1) + n;
    endfunction

endpackage : ws2812_pkg
`default_nettype wire

// File: rtl/ws2812_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_serializer
// Description : Continuously refreshes a WS2812 LED strip from pixel RAM.
//               Each frame reads number_of_pixels*3 bytes (address 0 first),
//               sends them MSB-first with NRZ pulse-width coding, then holds
//               the line low for a latch gap before the next frame.
// Revision    : 1.0  initial release
// ============================================================================
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              number_of_pixels,
    output logic [PIXEL_ADDR_W-1:0] pixel_addr,
    input  logic [7:0]              pixel_dbi,
    output logic                    ws2812_dout,
    output logic                    busy,
    output logic                    frame_done
);

    // Timing constants narrowed to their counter widths
    localparam logic [PHASE_W-1:0] c_bit_cycles = PHASE_W'(BIT_CYCLES);
    localparam logic [PHASE_W-1:0] c_t0h_cycles = PHASE_W'(T0H_CYCLES);
    localparam logic [PHASE_W-1:0] c_t1h_cycles = PHASE_W'(T1H_CYCLES);
    localparam logic [LATCH_W-1:0] c_latch_last = LATCH_W'(LATCH_CYCLES - 1);

    // Registered state
    ws_state_t               r_state;
    logic [LATCH_W-1:0]      r_latch_cnt;
    logic [PIXEL_ADDR_W-1:0] r_total;
    logic [PIXEL_ADDR_W-1:0] r_byte_idx;
    logic [PIXEL_ADDR_W-1:0] r_pixel_addr;
    logic [7:0]              r_shift;
    logic [2:0]              r_bit_cnt;
    logic [PHASE_W-1:0]      r_phase;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_dout;

    // Next-state values
    ws_state_t               w_state_nxt;
    logic [LATCH_W-1:0]      w_latch_cnt_nxt;
    logic [PIXEL_ADDR_W-1:0] w_total_nxt;
    logic [PIXEL_ADDR_W-1:0] w_byte_idx_nxt;
    logic [PIXEL_ADDR_W-1:0] w_pixel_addr_nxt;
    logic [7:0]              w_shift_nxt;
    logic [2:0]              w_bit_cnt_nxt;
    logic [PHASE_W-1:0]      w_phase_nxt;
    logic                    w_busy_nxt;
    logic                    w_frame_done_nxt;

    // Helpers
    logic [PIXEL_ADDR_W-1:0] w_npix_bytes;
    logic [PHASE_W-1:0]      w_high_len;
    logic [PHASE_W-1:0]      w_low_len;
    logic [PIXEL_ADDR_W-1:0] w_byte_idx_inc;

    assign w_npix_bytes   = frame_bytes(number_of_pixels);
    // shift_reg only moves between bits, so its MSB fixes the high time
    // for the whole bit, which is the same as choosing it on entry
    assign w_high_len     = r_shift[7] ? c_t1h_cycles : c_t0h_cycles;
    assign w_low_len      = c_bit_cycles - w_high_len;
    assign w_byte_idx_inc = r_byte_idx + PIXEL_ADDR_W'(1);

    // Sequencer next-state logic: latch gap, byte fetch and bit timing
    always_comb begin
        w_state_nxt      = r_state;
        w_latch_cnt_nxt  = r_latch_cnt;
        w_total_nxt      = r_total;
        w_byte_idx_nxt   = r_byte_idx;
        w_pixel_addr_nxt = r_pixel_addr;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_phase_nxt      = r_phase;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            LATCH: begin
                w_byte_idx_nxt = '0;
                if (r_latch_cnt == c_latch_last) begin
                    // pixel count is only looked at here, so mid-frame
                    // changes take effect on the following frame
                    w_total_nxt     = w_npix_bytes;
                    w_latch_cnt_nxt = '0;
                    if (w_npix_bytes != '0) begin
                        w_state_nxt      = FETCH;
                        w_busy_nxt       = 1'b1;
                        w_pixel_addr_nxt = '0;
                    end
                end else begin
                    w_latch_cnt_nxt = r_latch_cnt + LATCH_W'(1);
                end
            end

            // Address is presented for the whole FETCH cycle so the RAM
            // read data is valid during LOAD
            FETCH: begin
                w_state_nxt = LOAD;
            end

            LOAD: begin
                w_shift_nxt   = pixel_dbi;
                w_bit_cnt_nxt = 3'd7;
                w_phase_nxt   = '0;
                w_state_nxt   = BIT_HIGH;
            end

            BIT_HIGH: begin
                if (r_phase == w_high_len - PHASE_W'(1)) begin
                    w_phase_nxt = '0;
                    w_state_nxt = BIT_LOW;
                end else begin
                    w_phase_nxt = r_phase + PHASE_W'(1);
                end
            end

            BIT_LOW: begin
                if (r_phase == w_low_len - PHASE_W'(1)) begin
                    w_phase_nxt = '0;
                    if (r_bit_cnt != 3'd0) begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                        w_state_nxt   = BIT_HIGH;
                    end else if (w_byte_idx_inc == r_total) begin
                        w_byte_idx_nxt   = '0;
                        w_state_nxt      = LATCH;
                        w_busy_nxt       = 1'b0;
                        w_frame_done_nxt = 1'b1;
                        w_latch_cnt_nxt  = '0;
                    end else begin
                        w_byte_idx_nxt   = w_byte_idx_inc;
                        w_pixel_addr_nxt = w_byte_idx_inc;
                        w_state_nxt      = FETCH;
                    end
                end else begin
                    w_phase_nxt = r_phase + PHASE_W'(1);
                end
            end

            default: begin
                w_state_nxt     = LATCH;
                w_latch_cnt_nxt = '0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset forces a full latch gap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= LATCH;
            r_latch_cnt  <= '0;
            r_total      <= '0;
            r_byte_idx   <= '0;
            r_pixel_addr <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_phase      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_dout       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_latch_cnt  <= w_latch_cnt_nxt;
            r_total      <= w_total_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_pixel_addr <= w_pixel_addr_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            // line is high exactly while in BIT_HIGH, glitch-free from a flop
            r_dout       <= (w_state_nxt == BIT_HIGH);
        end
    end

    assign pixel_addr  = r_pixel_addr;
    assign ws2812_dout = r_dout;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;

endmodule : ws2812_serializer
`default_nettype wire

// File: tb/tb_ws2812_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_serializer
// Description : Self-checking bench for ws2812_serializer. A default-timing
//               instance runs table, hand-written and random scenarios; a
//               fast-timing instance sends full 255-pixel frames.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ws2812_serializer;

    localparam int BIT   = 34;
    localparam int T0H   = 11;
    localparam int T1H   = 22;
    localparam int LATCH = 2160;

    localparam int FBIT   = 4;
    localparam int FT0H   = 1;
    localparam int FT1H   = 2;
    localparam int FLATCH = 8;
    localparam int FBYTES = 765;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] number_of_pixels = 8'd0;
    logic [9:0] pixel_addr;
    logic [7:0] pixel_dbi = 8'd0;
    logic       ws2812_dout, busy, frame_done;

    logic       reset_f_n = 1'b0;
    logic [9:0] addr_f;
    logic [7:0] dbi_f = 8'd0;
    logic       dout_f, busy_f, fd_f;

    always #5 clk = ~clk;

    ws2812_serializer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .number_of_pixels (number_of_pixels),
        .pixel_addr       (pixel_addr),
        .pixel_dbi        (pixel_dbi),
        .ws2812_dout      (ws2812_dout),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    ws2812_serializer #(
        .BIT_CYCLES   (FBIT),
        .T0H_CYCLES   (FT0H),
        .T1H_CYCLES   (FT1H),
        .LATCH_CYCLES (FLATCH)
    ) dut_f (
        .clk              (clk),
        .reset_n          (reset_f_n),
        .number_of_pixels (8'd255),
        .pixel_addr       (addr_f),
        .pixel_dbi        (dbi_f),
        .ws2812_dout      (dout_f),
        .busy             (busy_f),
        .frame_done       (fd_f)
    );

    // RAM models with one clock of read latency
    logic [7:0] ram   [0:1023];
    logic [7:0] ram_f [0:1023];
    always @(posedge clk) begin
        pixel_dbi <= ram[pixel_addr];
        dbi_f     <= ram_f[addr_f];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main-instance monitor: edge times of dout/busy, frame_done times
    int   rise_q[$], fall_q[$], fd_q[$], brise_q[$], bfall_q[$];
    logic prev_dout = 1'b0, prev_busy = 1'b0;
    int   addr_max = 0;
    always @(negedge clk) begin
        prev_dout <= ws2812_dout;
        prev_busy <= busy;
        if (!reset_n) begin
            rise_q.delete(); fall_q.delete(); fd_q.delete();
            brise_q.delete(); bfall_q.delete();
            addr_max <= 0;
        end else begin
            if (ws2812_dout && !prev_dout) rise_q.push_back(cyc);
            if (!ws2812_dout && prev_dout) fall_q.push_back(cyc);
            if (busy && !prev_busy) brise_q.push_back(cyc);
            if (!busy && prev_busy) bfall_q.push_back(cyc);
            if (frame_done) fd_q.push_back(cyc);
            if (int'(pixel_addr) > addr_max) addr_max <= int'(pixel_addr);
        end
    end

    // Fast-instance monitor: decodes pulse widths back into bytes
    logic       prev_f = 1'b0;
    int         f_rise = 0, f_bits = 0, f_badlen = 0, f_addr_max = 0;
    logic [7:0] f_sr = 8'd0;
    logic [7:0] f_bytes[$];
    int         ffd_q[$];
    always @(negedge clk) begin
        prev_f <= dout_f;
        if (reset_f_n) begin
            if (dout_f && !prev_f) f_rise <= cyc;
            if (!dout_f && prev_f) begin
                if (cyc - f_rise != FT1H && cyc - f_rise != FT0H) f_badlen <= f_badlen + 1;
                f_sr <= {f_sr[6:0], (cyc - f_rise == FT1H)};
                if (f_bits == 7) begin
                    f_bytes.push_back({f_sr[6:0], (cyc - f_rise == FT1H)});
                    f_bits <= 0;
                end else begin
                    f_bits <= f_bits + 1;
                end
            end
            if (fd_f) ffd_q.push_back(cyc);
            if (int'(addr_f) > f_addr_max) f_addr_max <= int'(addr_f);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rel     = 0;
    int rel_f   = 0;

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: expected bit list derived from RAM and byte count
    bit exp_bits[$], exp_lbyte[$], exp_lframe[$];

    task automatic push_frame(input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            for (int b = 7; b >= 0; b--) begin
                exp_bits.push_back(ram[k][b]);
                exp_lbyte.push_back(b == 0);
                exp_lframe.push_back(b == 0 && k == nbytes - 1);
            end
        end
    endtask

    // Every bit is BIT clocks long; a byte boundary adds 2 low clocks and
    // a frame end adds the latch gap plus the 2 fetch clocks
    task automatic check_stream(input string tag, input int first_rise);
        int t, fs, f, h;
        t = first_rise; fs = first_rise; f = 0;
        check_int({tag, " pulses"}, rise_q.size(), exp_bits.size());
        for (int i = 0; i < exp_bits.size(); i++) begin
            if (i >= rise_q.size() || i >= fall_q.size()) break;
            h = exp_bits[i] ? T1H : T0H;
            check_int($sformatf("%s rise[%0d]", tag, i), rise_q[i], t);
            check_int($sformatf("%s high[%0d]", tag, i), fall_q[i] - rise_q[i], h);
            if (exp_lframe[i]) begin
                check_int($sformatf("%s frame_done[%0d]", tag, f),
                          (f < fd_q.size()) ? fd_q[f] : -1, t + BIT);
                check_int($sformatf("%s busy_rise[%0d]", tag, f),
                          (f < brise_q.size()) ? brise_q[f] : -1, fs - 2);
                check_int($sformatf("%s busy_fall[%0d]", tag, f),
                          (f < bfall_q.size()) ? bfall_q[f] : -1, t + BIT);
                f++;
                t  = t + BIT + LATCH + 2;
                fs = t;
            end else begin
                t = t + BIT + (exp_lbyte[i] ? 2 : 0);
            end
        end
        check_int({tag, " frame_done count"}, fd_q.size(), f);
    endtask

    task automatic do_reset(input logic [7:0] np);
        @(negedge clk);
        reset_n = 1'b0;
        number_of_pixels = np;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        exp_bits.delete(); exp_lbyte.delete(); exp_lframe.delete();
    endtask

    task automatic wait_frames(input string tag, input int n);
        for (int i = 0; i < 20000 && fd_q.size() < n; i++) @(posedge clk);
        if (fd_q.size() < n) check_int({tag, " timeout frames"}, fd_q.size(), n);
        @(posedge clk);
    endtask

    task automatic wait_first_rise(input string tag);
        for (int i = 0; i < 5000 && rise_q.size() == 0; i++) @(posedge clk);
        if (rise_q.size() == 0) check_int({tag, " timeout rise"}, 0, 1);
    endtask

    typedef struct {
        logic [7:0] npix;
        logic [7:0] b0, b1, b2, b3, b4, b5;
        int         exp_first_high;
        int         exp_max_addr;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int n1, n2;
        tbl[0] = '{8'd1, 8'h80, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, T1H, 2};
        tbl[1] = '{8'd2, 8'h01, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, T0H, 5};
        tbl[2] = '{8'd1, 8'hFF, 8'h7E, 8'h81, 8'h00, 8'h00, 8'h00, T1H, 2};

        for (int k = 0; k < 1024; k++) begin
            ram[k]   = 8'h00;
            ram_f[k] = 8'($urandom);
        end

        // Reset values
        repeat (3) @(negedge clk);
        check_int("reset dout", int'(ws2812_dout), 0);
        check_int("reset busy", int'(busy), 0);
        check_int("reset frame_done", int'(frame_done), 0);
        check_int("reset pixel_addr", int'(pixel_addr), 0);
        reset_f_n = 1'b1;
        rel_f = cyc;

        // Table-driven single-frame scenarios
        for (int v = 0; v < 3; v++) begin
            ram[0] = tbl[v].b0; ram[1] = tbl[v].b1; ram[2] = tbl[v].b2;
            ram[3] = tbl[v].b3; ram[4] = tbl[v].b4; ram[5] = tbl[v].b5;
            do_reset(tbl[v].npix);
            push_frame(3 * int'(tbl[v].npix));
            wait_frames($sformatf("tbl%0d", v), 1);
            check_stream($sformatf("tbl%0d", v), rel + LATCH + 2);
            check_int($sformatf("tbl%0d first_high", v),
                      (rise_q.size() > 0 && fall_q.size() > 0) ? fall_q[0] - rise_q[0] : -1,
                      tbl[v].exp_first_high);
            check_int($sformatf("tbl%0d max_addr", v), addr_max, tbl[v].exp_max_addr);
        end

        // npix=4, changed to 2 mid-frame: 12 bytes then 6
        for (int k = 0; k < 12; k++) ram[k] = 8'(8'h10 + k);
        do_reset(8'd4);
        push_frame(12);
        push_frame(6);
        wait_first_rise("npix4");
        number_of_pixels = 8'd2;
        wait_frames("npix4", 2);
        check_stream("npix4", rel + LATCH + 2);
        check_int("npix4 max_addr", addr_max, 11);

        // npix=0: line stays idle
        do_reset(8'd0);
        repeat (3 * LATCH + 10) @(posedge clk);
        check_int("npix0 rises", rise_q.size(), 0);
        check_int("npix0 frame_done", fd_q.size(), 0);
        check_int("npix0 busy", brise_q.size(), 0);
        check_int("npix0 max_addr", addr_max, 0);
        check_int("npix0 dout", int'(ws2812_dout), 0);

        // Reset while dout is high
        ram[0] = 8'hC5; ram[1] = 8'h3A; ram[2] = 8'h96;
        do_reset(8'd1);
        wait_first_rise("midrst");
        repeat (3) @(posedge clk);
        #2;
        check_int("midrst dout before", int'(ws2812_dout), 1);
        reset_n = 1'b0;
        #1;
        check_int("midrst dout", int'(ws2812_dout), 0);
        check_int("midrst busy", int'(busy), 0);
        check_int("midrst pixel_addr", int'(pixel_addr), 0);
        do_reset(8'd1);
        push_frame(3);
        wait_frames("midrst", 1);
        check_stream("midrst", rel + LATCH + 2);

        // Random RAM contents and pixel counts, count changed mid-frame
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 9; k++) ram[k] = 8'($urandom);
            n1 = int'($urandom_range(1, 3));
            n2 = int'($urandom_range(1, 3));
            do_reset(8'(n1));
            push_frame(3 * n1);
            push_frame(3 * n2);
            wait_first_rise($sformatf("rnd%0d", it));
            number_of_pixels = 8'(n2);
            wait_frames($sformatf("rnd%0d", it), 2);
            check_stream($sformatf("rnd%0d", it), rel + LATCH + 2);
            check_int($sformatf("rnd%0d max_addr", it), addr_max, 3 * ((n1 > n2) ? n1 : n2) - 1);
        end

        // Full 255-pixel frames on the fast instance
        for (int i = 0; i < 80000 && ffd_q.size() < 2; i++) @(posedge clk);
        check_int("npix255 frames", (ffd_q.size() >= 2) ? 2 : ffd_q.size(), 2);
        if (ffd_q.size() >= 2) begin
            check_int("npix255 first frame_done", ffd_q[0],
                      rel_f + FLATCH + 2 + FBYTES * 8 * FBIT + (FBYTES - 1) * 2);
            check_int("npix255 frame period", ffd_q[1] - ffd_q[0],
                      FBYTES * 8 * FBIT + (FBYTES - 1) * 2 + FLATCH + 2);
        end
        check_int("npix255 max_addr", f_addr_max, FBYTES - 1);
        check_int("npix255 pulse widths", f_badlen, 0);
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < FBYTES; k++)
                if (k >= f_bytes.size() || f_bytes[k] !== ram_f[k]) bad++;
            check_int("npix255 byte errors", bad, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ws2812_serializer
`default_nettype wire
